// File: rtl/wb_spi_slave_pkg.sv
// wb_spi_slave_pkg: register offsets, STATUS bit positions and frame states
// shared by the Wishbone SPI responder.
package wb_spi_slave_pkg;
    localparam logic [1:0] ADR_RXDATA = 2'd0;
    localparam logic [1:0] ADR_TXDATA = 2'd1;
    localparam logic [1:0] ADR_STATUS = 2'd2;
    localparam logic [1:0] ADR_CTRL   = 2'd3;

    localparam int STS_RX_VALID    = 0;
    localparam int STS_TX_FULL     = 1;
    localparam int STS_RX_OVERRUN  = 2;
    localparam int STS_BUSY        = 3;
    localparam int STS_TX_UNDERRUN = 4;

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;
endpackage

// File: rtl/wb_spi_slave_sync.sv
// spi_edge_sync: multi-flop synchronizer for an external pin with a
// previous-value flop producing single-cycle rise/fall pulses.
module spi_edge_sync #(
    parameter int stages = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [stages-1:0] sync;
    logic prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[stages-2:0], din};
            prev <= sync[stages-1];
        end
    end

    assign level = sync[stages-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;
endmodule

// File: rtl/wb_spi_slave.sv
// wb_spi_slave: mode-0 SPI responder oversampled in the system clock domain,
// exposing RX/TX bytes, status and control as Wishbone registers.
module wb_spi_slave
    import wb_spi_slave_pkg::*;
#(
    parameter logic [7:0] idle_byte   = 8'hFF,
    parameter int         sync_stages = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        irq
);
    logic sck_rise, sck_fall, cs_n, cs_fall, mosi;
    logic [3:0] unused_edges;
    logic unused;
    state_t state;
    logic enable, irq_en, rx_valid, tx_full, rx_overrun, tx_underrun;
    logic [7:0] rx_shift, rx_data, tx_shift, tx_hold;
    logic [2:0] bit_cnt;
    logic [1:0] adr;
    logic wb_req, rd_rx, wr_tx, wr_status, wr_ctrl;
    logic active, leave, start, shift_in, shift_out, load, done;
    logic [31:0] status, rd_data;

    spi_edge_sync #(.stages(sync_stages)) u_sck (
        .clk(clk), .rst(rst), .din(spi_sck),
        .level(unused_edges[0]), .rise(sck_rise), .fall(sck_fall)
    );
    spi_edge_sync #(.stages(sync_stages)) u_cs (
        .clk(clk), .rst(rst), .din(spi_cs_n),
        .level(cs_n), .rise(unused_edges[1]), .fall(cs_fall)
    );
    spi_edge_sync #(.stages(sync_stages)) u_mosi (
        .clk(clk), .rst(rst), .din(spi_mosi),
        .level(mosi), .rise(unused_edges[2]), .fall(unused_edges[3])
    );

    assign unused    = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:8]};
    assign adr       = wb_adr_i[3:2];
    assign wb_req    = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign rd_rx     = wb_req & ~wb_we_i & (adr == ADR_RXDATA);
    assign wr_tx     = wb_req & wb_we_i & (adr == ADR_TXDATA);
    assign wr_status = wb_req & wb_we_i & (adr == ADR_STATUS);
    assign wr_ctrl   = wb_req & wb_we_i & (adr == ADR_CTRL);

    // Leaving the frame outranks any sck edge seen in the same cycle.
    assign active    = state == ST_ACTIVE;
    assign leave     = active & (cs_n | ~enable);
    assign start     = ~active & cs_fall & enable;
    assign shift_in  = active & ~leave & sck_rise;
    assign shift_out = active & ~leave & sck_fall & (bit_cnt != 3'd0);
    assign load      = start | (active & ~leave & sck_fall & (bit_cnt == 3'd0));
    assign done      = shift_in & (bit_cnt == 3'd7);
    assign spi_miso  = active & tx_shift[7];

    always_comb begin
        status = '0;
        status[STS_RX_VALID]    = rx_valid;
        status[STS_TX_FULL]     = tx_full;
        status[STS_RX_OVERRUN]  = rx_overrun;
        status[STS_BUSY]        = active;
        status[STS_TX_UNDERRUN] = tx_underrun;
        rd_data = (adr == ADR_RXDATA) ? {24'h0, rx_data} :
                  (adr == ADR_STATUS) ? status :
                  (adr == ADR_CTRL)   ? {30'h0, irq_en, enable} : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_ack_o    <= 1'b0;
            wb_dat_o    <= '0;
            irq         <= 1'b0;
            state       <= ST_IDLE;
            enable      <= 1'b0;
            irq_en      <= 1'b0;
            rx_valid    <= 1'b0;
            tx_full     <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
            rx_shift    <= '0;
            rx_data     <= '0;
            tx_hold     <= '0;
            tx_shift    <= idle_byte;
            bit_cnt     <= '0;
        end else begin
            wb_ack_o <= wb_req;
            if (wb_req & ~wb_we_i) wb_dat_o <= rd_data;
            if (wr_ctrl) {irq_en, enable} <= wb_dat_i[1:0];
            if (wr_tx) tx_hold <= wb_dat_i[7:0];
            // Setting events win over same-cycle clears (reads, W1C, loads).
            tx_full     <= wr_tx | (tx_full & ~load);
            tx_underrun <= (load & ~tx_full) | (tx_underrun & ~(wr_status & wb_dat_i[STS_TX_UNDERRUN]));
            rx_overrun  <= (done & rx_valid & ~rd_rx) | (rx_overrun & ~(wr_status & wb_dat_i[STS_RX_OVERRUN]));
            rx_valid    <= done | (rx_valid & ~rd_rx);
            if (done) rx_data <= {rx_shift[6:0], mosi};
            irq <= irq_en & rx_valid;
            if (leave) state <= ST_IDLE;
            else if (start) state <= ST_ACTIVE;
            if (start) bit_cnt <= '0;
            else if (shift_in) bit_cnt <= bit_cnt + 3'd1;
            if (shift_in) rx_shift <= {rx_shift[6:0], mosi};
            if (load) tx_shift <= tx_full ? tx_hold : idle_byte;
            else if (shift_out) tx_shift <= {tx_shift[6:0], 1'b0};
        end
    end
endmodule

// File: tb/tb_wb_spi_slave.sv
// tb_wb_spi_slave: bit-banged SPI master plus Wishbone host; register reads are
// scoreboarded and checked when the ack returns.
module tb_wb_spi_slave;
    import wb_spi_slave_pkg::*;

    logic        clk = 1'b0, rst = 1'b0;
    logic [31:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
    logic [3:0]  wb_sel_i = 4'hF;
    logic        wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0, wb_ack_o;
    logic        spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0, spi_miso, irq;
    int errors = 0, checks = 0;

    typedef struct {string name; logic [31:0] exp;} sb_t;
    sb_t sb[$];
    sb_t e;

    typedef struct {
        logic [7:0]  tx;
        logic        has_tx;
        logic [7:0]  mosi;
        logic [7:0]  miso;
        logic [31:0] status;
    } vec_t;
    vec_t vecs[5];

    wb_spi_slave dut (
        .clk(clk), .rst(rst),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
        .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
        .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, required finish before timeout");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (wb_ack_o && !wb_we_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got read ack with data %h, required no ack", wb_dat_o);
            end else begin
                e = sb.pop_front();
                chk(e.name, wb_dat_o, e.exp);
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus(input logic we, input logic [1:0] a, input logic [31:0] d);
        wb_adr_i = {28'h0, a, 2'b00};
        wb_dat_i = d;
        wb_we_i  = we;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (wb_ack_o) break;
        end
        if (!wb_ack_o) begin
            checks++;
            errors++;
            $display("FAIL bus_timeout: got no ack at adr %0d, required ack within 4 cycles", a);
        end
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus(1'b1, a, d);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        sb.push_back('{name, exp});
        bus(1'b0, a, '0);
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        wait_clk(8);
    endtask

    // sck falls together with cs_n rising, so the frame ends without a final tx load
    task automatic cs_high();
        spi_sck  = 1'b0;
        spi_cs_n = 1'b1;
        wait_clk(8);
    endtask

    // Bits hi..lo at clk/8; leaves sck high after the last bit.
    task automatic xfer(input logic [7:0] mo, input int hi, input int lo, inout logic [7:0] mi);
        for (int i = hi; i >= lo; i--) begin
            spi_sck  = 1'b0;
            spi_mosi = mo[i];
            wait_clk(4);
            mi[i]   = spi_miso;
            spi_sck = 1'b1;
            wait_clk(4);
        end
    endtask

    task automatic frame(input logic [7:0] mo, output logic [7:0] mi);
        logic [7:0] t;
        t = '0;
        cs_low();
        xfer(mo, 7, 0, t);
        cs_high();
        mi = t;
    endtask

    initial begin
        logic [7:0] m0, m1;
        vecs = '{
            '{8'hA5, 1'b1, 8'h3C, 8'hA5, 32'h01},
            '{8'h00, 1'b0, 8'h55, 8'hFF, 32'h11},
            '{8'h81, 1'b1, 8'h7E, 8'h81, 32'h01},
            '{8'h00, 1'b1, 8'hFF, 8'h00, 32'h01},
            '{8'hC3, 1'b0, 8'h00, 8'hFF, 32'h11}
        };

        // reset state
        wait_clk(3);
        chk("rst_ack", wb_ack_o, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_miso", spi_miso, 0);
        chk("rst_irq", irq, 0);
        rst = 1'b1;
        wait_clk(2);
        rd(ADR_STATUS, 32'h0, "rst_status");
        rd(ADR_CTRL, 32'h0, "rst_ctrl");
        rd(ADR_RXDATA, 32'h0, "rst_rxdata");

        // basic exchange
        wr(ADR_CTRL, 32'h1);
        rd(ADR_CTRL, 32'h1, "t1_ctrl");
        wr(ADR_TXDATA, 32'hA5);
        rd(ADR_STATUS, 32'h02, "t1_status_txfull");
        cs_low();
        m0 = '0;
        xfer(8'h3C, 7, 0, m0);
        rd(ADR_STATUS, 32'h09, "t1_status_frame");
        cs_high();
        chk("t1_miso", m0, 8'hA5);
        rd(ADR_STATUS, 32'h01, "t1_status_after");
        rd(ADR_RXDATA, 32'h3C, "t1_rxdata");
        rd(ADR_STATUS, 32'h00, "t1_status_read");

        // vector table: exchange, underrun, W1C
        foreach (vecs[i]) begin
            if (vecs[i].has_tx) wr(ADR_TXDATA, {24'h0, vecs[i].tx});
            frame(vecs[i].mosi, m0);
            chk($sformatf("v%0d_miso", i), m0, vecs[i].miso);
            rd(ADR_STATUS, vecs[i].status, $sformatf("v%0d_status", i));
            rd(ADR_RXDATA, {24'h0, vecs[i].mosi}, $sformatf("v%0d_rxdata", i));
            wr(ADR_STATUS, 32'h10);
            rd(ADR_STATUS, 32'h0, $sformatf("v%0d_status_clr", i));
        end

        // overrun and irq
        wr(ADR_CTRL, 32'h3);
        cs_low();
        m0 = '0;
        xfer(8'h11, 7, 0, m0);
        wait_clk(2);
        chk("t3_irq_set", irq, 1);
        xfer(8'h22, 7, 0, m0);
        cs_high();
        rd(ADR_STATUS, 32'h15, "t3_status");
        rd(ADR_RXDATA, 32'h22, "t3_rxdata");
        wait_clk(2);
        chk("t3_irq_clr", irq, 0);
        wr(ADR_STATUS, 32'h14);
        rd(ADR_STATUS, 32'h0, "t3_status_clr");
        wr(ADR_CTRL, 32'h1);

        // abort after 5 bits
        cs_low();
        m0 = '0;
        xfer(8'hFF, 7, 3, m0);
        cs_high();
        rd(ADR_STATUS, 32'h10, "t4_status_abort");
        wr(ADR_STATUS, 32'h10);
        wr(ADR_TXDATA, 32'h96);
        frame(8'h81, m0);
        chk("t4_miso", m0, 8'h96);
        rd(ADR_RXDATA, 32'h81, "t4_rxdata");
        rd(ADR_STATUS, 32'h0, "t4_status");

        // back-to-back with a TXDATA write during byte 0
        wr(ADR_TXDATA, 32'h12);
        cs_low();
        m0 = '0;
        m1 = '0;
        xfer(8'h5A, 7, 4, m0);
        rd(ADR_STATUS, 32'h08, "t5_status_mid");
        wr(ADR_TXDATA, 32'h34);
        rd(ADR_STATUS, 32'h0A, "t5_status_full");
        xfer(8'h5A, 3, 0, m0);
        rd(ADR_RXDATA, 32'h5A, "t5_rx0");
        rd(ADR_STATUS, 32'h0A, "t5_status_b0");
        xfer(8'hA6, 7, 0, m1);
        rd(ADR_STATUS, 32'h09, "t5_status_b1");
        cs_high();
        chk("t5_miso0", m0, 8'h12);
        chk("t5_miso1", m1, 8'h34);
        rd(ADR_RXDATA, 32'hA6, "t5_rx1");

        // reset mid-frame at bit 4
        wr(ADR_TXDATA, 32'h77);
        cs_low();
        m0 = '0;
        xfer(8'hF0, 7, 4, m0);
        rst = 1'b0;
        wait_clk(2);
        chk("t6_miso", spi_miso, 0);
        chk("t6_irq", irq, 0);
        chk("t6_ack", wb_ack_o, 0);
        chk("t6_dat", wb_dat_o, 0);
        rst = 1'b1;
        rd(ADR_STATUS, 32'h0, "t6_status");
        rd(ADR_CTRL, 32'h0, "t6_ctrl");
        xfer(8'hF0, 3, 0, m0);
        rd(ADR_STATUS, 32'h0, "t6_status_nocap");
        cs_high();
        rd(ADR_RXDATA, 32'h0, "t6_rxdata_nocap");
        wr(ADR_CTRL, 32'h1);
        frame(8'h3C, m0);
        chk("t6_miso_after", m0, 8'hFF);
        rd(ADR_RXDATA, 32'h3C, "t6_rxdata");
        rd(ADR_STATUS, 32'h10, "t6_status_after");

        wait_clk(2);
        chk("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
